// File: rtl/mux_tree_pkg.sv
// Shared defaults, log2 helper and tree/stage layout helpers for the mux tree.
// No logic, no latency, no flow control of its own.
// Consumed by mux2_level and mux_tree_pipe via import.
package mux_tree_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_N_IN  = 4;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Stage record {valid, sel, par, data}, packed LSB-first from data upward.
    function automatic int rec_data_lsb();
        return 0;
    endfunction

    function automatic int rec_par_bit(input int dw);
        return dw;
    endfunction

    function automatic int rec_sel_lsb(input int dw);
        return dw + 1;
    endfunction

    function automatic int rec_valid_bit(input int dw, input int sw);
        return dw + 1 + sw;
    endfunction

    function automatic int rec_width(input int dw, input int sw);
        return dw + sw + 2;
    endfunction

    // First node index of tree level lvl in a flat bus holding all levels.
    function automatic int tree_off(input int n_in, input int lvl);
        return n_in - (n_in >> lvl);
    endfunction

endpackage

// File: rtl/mux2_level.sv
// One mux-tree level: N_PAIRS 2:1 muxes steered by sel bit LVL, registered; valid/sel ride along.
// Latency: 1 cycle. Parity lanes exist only when MUX_TREE_PARITY_EN is defined.
// Backpressure: loads only when en is high, otherwise every register holds.
module mux2_level
    import mux_tree_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int N_PAIRS = 1,
    parameter int SEL_W   = 1,
    parameter int LVL     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       in_vld,
    input  logic [SEL_W-1:0]           in_sel,
    input  logic [2*N_PAIRS*WIDTH-1:0] in_dat,
`ifdef MUX_TREE_PARITY_EN
    input  logic [2*N_PAIRS-1:0]       in_par,
    output logic [N_PAIRS-1:0]         out_par,
`endif
    output logic                       out_vld,
    output logic [SEL_W-1:0]           out_sel,
    output logic [N_PAIRS*WIDTH-1:0]   out_dat
);

    logic                     pick;
    logic [N_PAIRS*WIDTH-1:0] mux_dat;

    assign pick = in_sel[LVL];

    always_comb begin
        mux_dat = '0;
        for (int p = 0; p < N_PAIRS; p++) begin
            mux_dat[p*WIDTH +: WIDTH] = pick ? in_dat[(2*p+1)*WIDTH +: WIDTH]
                                             : in_dat[(2*p)*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_sel <= '0;
            out_dat <= '0;
        end else if (en) begin
            out_vld <= in_vld;
            out_sel <= in_sel;
            out_dat <= mux_dat;
        end
    end

`ifdef MUX_TREE_PARITY_EN
    logic [N_PAIRS-1:0] mux_par;

    always_comb begin
        mux_par = '0;
        for (int p = 0; p < N_PAIRS; p++) begin
            mux_par[p] = pick ? in_par[2*p+1] : in_par[2*p];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_par <= '0;
        end else if (en) begin
            out_par <= mux_par;
        end
    end
`endif

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N_IN:1 channel select built from LEVELS registered 2:1 levels; optional MUX_TREE_PARITY_EN.
// Latency: LEVELS cycles accept-to-out_valid, plus one per stalled cycle; 1 beat/cycle.
// Backpressure: single global enable adv = out_ready | ~out_valid; in_ready = adv, bubbles kept.
module mux_tree_pipe
    import mux_tree_pkg::*;
#(
    parameter  int WIDTH  = DEF_WIDTH,
    parameter  int N_IN   = DEF_N_IN,
    localparam int LEVELS = clog2(N_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    input  logic [LEVELS-1:0]       in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [LEVELS-1:0]       out_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_par
);

    // Every level's node registers packed into flat buses; level l starts at node tree_off(N_IN, l).
    logic                       adv;
    logic [(N_IN-1)*WIDTH-1:0]  tree_dat;
    logic [LEVELS-1:0]          tree_vld;
    logic [LEVELS*LEVELS-1:0]   tree_sel;

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

`ifdef MUX_TREE_PARITY_EN
    logic [N_IN-1:0] ch_par;
    logic [N_IN-2:0] tree_par;

    always_comb begin
        ch_par = '0;
        for (int k = 0; k < N_IN; k++) begin
            ch_par[k] = ^in_data[k*WIDTH +: WIDTH];
        end
    end
`endif

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int NP  = N_IN >> (l + 1);
        localparam int OFF = tree_off(N_IN, l);

        if (l == 0) begin : g_head
            mux2_level #(
                .WIDTH   (WIDTH),
                .N_PAIRS (NP),
                .SEL_W   (LEVELS),
                .LVL     (0)
            ) u_lvl (
                .clk     (clk),
                .rst     (rst),
                .en      (adv),
                .in_vld  (in_valid),
                .in_sel  (in_sel),
                .in_dat  (in_data),
`ifdef MUX_TREE_PARITY_EN
                .in_par  (ch_par),
                .out_par (tree_par[OFF +: NP]),
`endif
                .out_vld (tree_vld[0]),
                .out_sel (tree_sel[0 +: LEVELS]),
                .out_dat (tree_dat[OFF*WIDTH +: NP*WIDTH])
            );
        end else begin : g_body
            localparam int POFF = tree_off(N_IN, l - 1);

            mux2_level #(
                .WIDTH   (WIDTH),
                .N_PAIRS (NP),
                .SEL_W   (LEVELS),
                .LVL     (l)
            ) u_lvl (
                .clk     (clk),
                .rst     (rst),
                .en      (adv),
                .in_vld  (tree_vld[l-1]),
                .in_sel  (tree_sel[(l-1)*LEVELS +: LEVELS]),
                .in_dat  (tree_dat[POFF*WIDTH +: 2*NP*WIDTH]),
`ifdef MUX_TREE_PARITY_EN
                .in_par  (tree_par[POFF +: 2*NP]),
                .out_par (tree_par[OFF +: NP]),
`endif
                .out_vld (tree_vld[l]),
                .out_sel (tree_sel[l*LEVELS +: LEVELS]),
                .out_dat (tree_dat[OFF*WIDTH +: NP*WIDTH])
            );
        end
    end

    // The root node is the last slot of each flat bus.
    assign out_valid = tree_vld[LEVELS-1];
    assign out_sel   = tree_sel[(LEVELS-1)*LEVELS +: LEVELS];
    assign out_data  = tree_dat[(N_IN-2)*WIDTH +: WIDTH];

`ifdef MUX_TREE_PARITY_EN
    assign out_par = tree_par[N_IN-2];
`else
    assign out_par = 1'b0;
`endif

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Scoreboard bench for mux_tree_pipe: a 4x8 instance and an 8x1 instance, directed vectors.
module tb_mux_tree_pipe;

`ifdef MUX_TREE_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    localparam logic [31:0] CH = 32'hD3_00_5A_A5;

    typedef struct {
        logic [7:0] dat;
        logic [1:0] sel;
        logic       par;
        int         t;
        int         s;
    } exp_t;

    typedef struct {
        logic       dat;
        logic [2:0] sel;
        int         t;
    } exp8_t;

    logic clk = 1'b0;
    logic rst;

    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic        in_valid, in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_valid, out_ready, out_par;

    logic [7:0]  in_data8;
    logic [2:0]  in_sel8;
    logic        in_valid8, in_ready8;
    logic        out_data8;
    logic [2:0]  out_sel8;
    logic        out_valid8, out_ready8, out_par8;

    exp_t  sb_q[$];
    exp8_t sb8_q[$];
    exp_t  m_e;
    exp8_t m_e8;

    int n_checks = 0;
    int n_pass   = 0;
    int cnt      = 0;
    int stall_cnt = 0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_dat;
    logic [1:0] prev_sel;
    bit seen3;

    logic [7:0] exp2 [4] = '{8'hA5, 8'h5A, 8'h00, 8'hD3};
    logic       par2 [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    mux_tree_pipe #(.WIDTH(8), .N_IN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_par   (out_par)
    );

    mux_tree_pipe #(.WIDTH(1), .N_IN(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data8),
        .in_sel    (in_sel8),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .out_data  (out_data8),
        .out_sel   (out_sel8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_par   (out_par8)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Monitor for the 4x8 instance: hold checks under stall, then pop-and-compare on each handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_dat);
                check("hold_sel", out_sel, prev_sel);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_unexpected: got beat data=%0h sel=%0d, required no beat", out_data, out_sel);
                end else begin
                    m_e = sb_q.pop_front();
                    check("out_data", out_data, m_e.dat);
                    check("out_sel", out_sel, m_e.sel);
                    check("out_par", out_par, m_e.par);
                    check("latency", cnt - m_e.t - (stall_cnt - m_e.s), 2);
                end
            end
        end
        prev_stall = !rst && out_valid && !out_ready;
        prev_dat   = out_data;
        prev_sel   = out_sel;
        if (!rst && out_valid && !out_ready) stall_cnt++;
    end

    always @(negedge clk) begin
        if (!rst && out_valid8 && out_ready8) begin
            if (sb8_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb8_unexpected: got beat sel=%0d, required no beat", out_sel8);
            end else begin
                m_e8 = sb8_q.pop_front();
                check("out8_data", out_data8, m_e8.dat);
                check("out8_sel", out_sel8, m_e8.sel);
                check("out8_par", out_par8, m_e8.dat & PAR_ON);
                check("latency8", cnt - m_e8.t, 3);
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [1:0] s, input logic [7:0] ed, input logic ep);
        exp_t e;
        bit ok;
        ok = 1'b0;
        in_data  = d;
        in_sel   = s;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.dat = ed;
                e.sel = s;
                e.par = ep & PAR_ON;
                e.t   = cnt;
                e.s   = stall_cnt;
                sb_q.push_back(e);
                ok = 1'b1;
            end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, required acceptance");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic [7:0] d, input logic [2:0] s, input logic ed);
        exp8_t e;
        bit ok;
        ok = 1'b0;
        in_data8  = d;
        in_sel8   = s;
        in_valid8 = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready8) begin
                e.dat = ed;
                e.sel = s;
                e.t   = cnt;
                sb8_q.push_back(e);
                ok = 1'b1;
            end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL accept8_timeout: got in_ready=0 for 50 cycles, required acceptance");
        end
        @(posedge clk);
        #1;
    endtask

    // Garbage on the inputs while idle must not reach beats already in flight.
    task automatic idle();
        in_valid = 1'b0;
        in_data  = 32'hFFFF_FFFF;
        in_sel   = 2'd3;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
        check("drain", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain8();
        for (int i = 0; i < 40 && sb8_q.size() != 0; i++) @(negedge clk);
        check("drain8", sb8_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100000, required finish");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        // Reset held with a valid beat offered: nothing may come out.
        rst        = 1'b1;
        in_data    = CH;
        in_sel     = 2'd3;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        in_data8   = 8'h00;
        in_sel8    = 3'd0;
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_sel", out_sel, 0);
        check("rst_out_par", out_par, 0);
        check("rst_out8_valid", out_valid8, 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back through every channel.
        for (int i = 0; i < 4; i++) send(CH, 2'(i), exp2[i], par2[i]);
        idle();
        drain();

        // Three stall cycles with the first beat parked on the output.
        out_ready = 1'b0;
        seen3 = 1'b0;
        fork
            begin
                send(CH, 2'd3, 8'hD3, 1'b1);
                send(CH, 2'd2, 8'h00, 1'b0);
                send(CH, 2'd1, 8'h5A, 1'b0);
                send(CH, 2'd0, 8'hA5, 1'b0);
                idle();
            end
            begin
                for (int i = 0; i < 20 && !seen3; i++) begin
                    @(negedge clk);
                    seen3 = out_valid;
                end
                if (!seen3) begin
                    n_checks++;
                    $display("FAIL bp_wait: got out_valid=0 for 20 cycles, required 1");
                end else begin
                    for (int k = 0; k < 3; k++) begin
                        if (k > 0) @(negedge clk);
                        check("bp_in_ready", in_ready, 0);
                        check("bp_out_data", out_data, 8'hD3);
                    end
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Two beats in flight, then an async reset pulse between edges.
        send(CH, 2'd2, 8'h00, 1'b0);
        send(CH, 2'd1, 8'h5A, 1'b0);
        #1 rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 8'h00);
        #1 rst = 1'b0;
        sb_q.delete();
        @(posedge clk);
        #1;
        send(CH, 2'd3, 8'hD3, 1'b1);
        send(CH, 2'd0, 8'hA5, 1'b0);
        idle();
        drain();

        // 8:1, 1-bit: walking one against every select value.
        for (int h = 0; h < 8; h++) begin
            for (int s = 0; s < 8; s++) begin
                send8(8'(1 << h), 3'(s), (s == h));
            end
        end
        in_valid8 = 1'b0;
        drain8();

        // Parity: 07 has three ones, 03 has two.
        send(32'h00_00_03_07, 2'd0, 8'h07, 1'b1);
        send(32'h00_00_03_07, 2'd1, 8'h03, 1'b0);
        idle();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
